// File: rtl/router_pkg.sv
// Shared types and helpers for the buffered packet router.
package router_pkg;

   localparam int NUM_PORTS_MAX = 16;

   typedef logic [$clog2(NUM_PORTS_MAX)-1:0] port_idx_t;

   function automatic int addr_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata shows the head whenever not empty.
module router_fifo
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_WIDTH-1:0]         wdata,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        count_q, count_d;
   logic                  do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   // A full FIFO refuses the push even if it pops in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/buffered_router.sv
// 1-to-NUM_PORTS router: steers each input word by addr into a per-port FWFT queue.
module buffered_router
   import router_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_PORTS  = 4,
   parameter  int FIFO_DEPTH = 4,
   parameter  int CNT_WIDTH  = 16,
   localparam int ADDR_WIDTH = addr_width(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [DATA_WIDTH-1:0]           din,
   input  logic                            din_valid,
   output logic                            din_ready,
   input  logic [ADDR_WIDTH-1:0]           addr,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
   output logic [NUM_PORTS-1:0]            dout_valid,
   input  logic [NUM_PORTS-1:0]            dout_ready,
   output logic [CNT_WIDTH-1:0]            drop_cnt
);

   localparam int ADDR_SPAN = 1 << ADDR_WIDTH;
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_PORTS-1:0]                  push, full, empty;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata;
   logic [NUM_PORTS-1:0][CNT_W-1:0]       fifo_count_unused;
   logic [ADDR_SPAN-1:0]                  full_span;
   logic                                  addr_legal, accept;
   logic [CNT_WIDTH-1:0]                  drop_cnt_q, drop_cnt_d;

   if (ADDR_SPAN == NUM_PORTS) begin : g_pow2
      assign addr_legal = 1'b1;
   end else begin : g_npow2
      assign addr_legal = (addr < ADDR_WIDTH'(NUM_PORTS));
   end

   // Pad to the full address span so the ready mux never indexes out of range.
   always_comb begin
      full_span = '1;
      for (int p = 0; p < NUM_PORTS; p++) begin
         full_span[p] = full[p];
      end
   end

   assign din_ready = addr_legal ? !full_span[addr] : 1'b1;
   assign accept    = din_valid && din_ready;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign push[p] = accept && addr_legal && (addr == ADDR_WIDTH'(p));

      router_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[p]),
         .pop   (dout_ready[p]),
         .wdata (din),
         .rdata (rdata[p]),
         .full  (full[p]),
         .empty (empty[p]),
         .count (fifo_count_unused[p])
      );

      assign dout_valid[p]                    = !empty[p];
      assign dout[p*DATA_WIDTH +: DATA_WIDTH] = empty[p] ? '0 : rdata[p];
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (accept && !addr_legal && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_buffered_router.sv
// Directed bench for buffered_router with a per-port expected-word scoreboard.
module tb_buffered_router;

   logic         clk, rst_n;
   logic [31:0]  din;
   logic [1:0]   addr;
   logic         din_valid, din_valid3;
   logic [3:0]   dout_ready;

   logic         din_ready;
   logic [127:0] dout;
   logic [3:0]   dout_valid;
   logic [15:0]  drop_cnt;

   logic         rdy3, rdy3s;
   logic [95:0]  dout3, dout3s;
   logic [2:0]   dv3, dv3s;
   logic [15:0]  drop3;
   logic [1:0]   drop3s;

   logic [31:0]  exp_q [4][$];
   int           passed = 0;
   int           total  = 0;

   buffered_router #(.DATA_WIDTH(32), .NUM_PORTS(4), .FIFO_DEPTH(4), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .addr(addr), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .drop_cnt(drop_cnt));

   buffered_router #(.DATA_WIDTH(32), .NUM_PORTS(3), .FIFO_DEPTH(4), .CNT_WIDTH(16)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid3), .din_ready(rdy3),
      .addr(addr), .dout(dout3), .dout_valid(dv3), .dout_ready(3'b111),
      .drop_cnt(drop3));

   buffered_router #(.DATA_WIDTH(32), .NUM_PORTS(3), .FIFO_DEPTH(4), .CNT_WIDTH(2)) u_dut3s (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid3), .din_ready(rdy3s),
      .addr(addr), .dout(dout3s), .dout_valid(dv3s), .dout_ready(3'b111),
      .drop_cnt(drop3s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int model_words();
      int n = 0;
      for (int p = 0; p < 4; p++) n += exp_q[p].size();
      return n;
   endfunction

   // Checks the 4-port DUT against the model, then advances the model and one clock.
   task automatic cycle();
      logic        exp_rdy;
      logic [31:0] exp_lane;
      #2;
      for (int p = 0; p < 4; p++) begin
         exp_lane = (exp_q[p].size() != 0) ? exp_q[p][0] : 32'h0;
         chk("dout_valid", 128'(dout_valid[p]), 128'(exp_q[p].size() != 0));
         chk("dout_lane", 128'(dout[p*32 +: 32]), 128'(exp_lane));
      end
      exp_rdy = (exp_q[addr].size() < 4);
      if (din_valid) chk("din_ready", 128'(din_ready), 128'(exp_rdy));
      for (int p = 0; p < 4; p++) begin
         if (dout_ready[p] && exp_q[p].size() != 0) void'(exp_q[p].pop_front());
      end
      if (din_valid && exp_rdy) exp_q[addr].push_back(din);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && model_words() != 0; k++) cycle();
      cycle();
   endtask

   initial begin
      rst_n = 1'b0; din = '0; addr = '0; din_valid = 1'b0; din_valid3 = 1'b0;
      dout_ready = 4'b1111;
      #2;
      chk("rst dout_valid", 128'(dout_valid), 128'(0));
      chk("rst dout", dout, 128'(0));
      chk("rst drop_cnt", 128'(drop_cnt), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("ready after reset", 128'(din_ready), 128'(1));
      @(posedge clk); #1;

      // single route
      din = 32'hA5A5_0001; addr = 2'd2; din_valid = 1'b1;
      cycle();
      din_valid = 1'b0;
      chk("t2 dout_valid", 128'(dout_valid), 128'(4'b0100));
      chk("t2 lane2", 128'(dout[64 +: 32]), 128'(32'hA5A5_0001));
      chk("t2 other lanes", 128'({dout[127:96], dout[63:0]}), 128'(0));
      drain();

      // fill and backpressure on port 1
      dout_ready = 4'b1101; addr = 2'd1; din_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         din = 32'h3000_0000 + 32'(i);
         cycle();
      end
      din = 32'h3000_0005;
      #1;
      chk("t3 held", 128'(din_ready), 128'(0));
      cycle();
      cycle();
      dout_ready[1] = 1'b1;
      cycle();
      cycle();
      din_valid = 1'b0;
      drain();

      // independence: port 0 full and stalled, port 3 still flows
      dout_ready = 4'b1110; addr = 2'd0; din_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = 32'h4000_0000 + 32'(i);
         cycle();
      end
      addr = 2'd3; din = 32'h4333_0003;
      #1;
      chk("t4 ready port3", 128'(din_ready), 128'(1));
      cycle();
      din_valid = 1'b0;
      cycle();
      chk("t4 port0 still valid", 128'(dout_valid[0]), 128'(1));
      addr = 2'd0; din_valid = 1'b1; din = 32'h4000_00FF;
      #1;
      chk("t4 port0 full", 128'(din_ready), 128'(0));
      din_valid = 1'b0;
      dout_ready = 4'b1111;
      drain();

      // simultaneous push/pop on port 2 holding two words
      dout_ready = 4'b1011; addr = 2'd2; din_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         din = 32'h5000_0000 + 32'(i);
         cycle();
      end
      dout_ready[2] = 1'b1;
      for (int i = 2; i < 12; i++) begin
         din = 32'h5000_0000 + 32'(i);
         cycle();
      end
      din_valid = 1'b0; dout_ready[2] = 1'b0;
      cycle();
      dout_ready[2] = 1'b1;
      cycle();
      cycle();
      cycle();

      // illegal address on 3-port instances
      addr = 2'd3; din_valid3 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = 32'h6000_0000 + 32'(i);
         #1;
         chk("t6 ready", 128'(rdy3), 128'(1));
         chk("t6 ready sat", 128'(rdy3s), 128'(1));
         cycle();
         chk("t6 no valid", 128'(dv3), 128'(0));
         chk("t6 no data", 128'(dout3), 128'(0));
      end
      din_valid3 = 1'b0;
      chk("t6 drop_cnt", 128'(drop3), 128'(8));
      chk("t6 drop_cnt sat", 128'(drop3s), 128'(3));
      addr = 2'd2; din = 32'h6666_0002; din_valid3 = 1'b1;
      cycle();
      din_valid3 = 1'b0;
      chk("t6 legal valid", 128'(dv3), 128'(3'b100));
      chk("t6 legal lane", 128'(dout3[64 +: 32]), 128'(32'h6666_0002));
      chk("t6 legal no drop", 128'(drop3), 128'(8));
      cycle();

      // reset mid-run with words queued and nonzero drop counters
      dout_ready = 4'b0000; addr = 2'd1; din_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 32'h7000_0000 + 32'(i);
         cycle();
      end
      din_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid rst dout_valid", 128'(dout_valid), 128'(0));
      chk("mid rst dout", dout, 128'(0));
      chk("mid rst drop3", 128'(drop3), 128'(0));
      chk("mid rst drop3s", 128'(drop3s), 128'(0));
      for (int p = 0; p < 4; p++) exp_q[p].delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("mid rst ready", 128'(din_ready), 128'(1));
      dout_ready = 4'b1111;
      cycle();
      cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
